// File: rtl/colproc_pipe.sv
// rtl/colproc_pipe.sv - delay-aligned colour-reduction pipeline for the ZBT write path
//
// Delays a packed multi-pixel word and its write address by DELAY cycles in a
// circular buffer. It then clears a configurable number of LSBs per colour
// channel and registers the result, with a valid strobe.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   pix_in         packed pixels, pixel k at [(k+1)*3*CH_BITS-1 : k*3*CH_BITS], {R,G,B}
//   pix_in_valid   pix_in / write_addr qualify this cycle
//   write_addr     destination address paired with pix_in
//   switch_vals    requested number of LSBs to clear
//   switch_sels    target channel: 00 R, 01 G, 10 B, 11 all
//   change         debounced button level; its rising edge commits the switches
//   pix_out        truncated pixels
//   pix_out_addr   address aligned with pix_out
//   pix_out_valid  pix_out / pix_out_addr qualify this cycle

module colproc_pipe #(
  parameter int PIX_PER_WORD = 2,
  parameter int CH_BITS      = 6,
  parameter int ADDR_W       = 19,
  parameter int DELAY        = 80
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [PIX_PER_WORD*3*CH_BITS-1:0]   pix_in,
  input  logic                                pix_in_valid,
  input  logic [ADDR_W-1:0]                   write_addr,
  input  logic [2:0]                          switch_vals,
  input  logic [1:0]                          switch_sels,
  input  logic                                change,
  output logic [PIX_PER_WORD*3*CH_BITS-1:0]   pix_out,
  output logic [ADDR_W-1:0]                   pix_out_addr,
  output logic                                pix_out_valid
);

  localparam int W  = PIX_PER_WORD * 3 * CH_BITS;
  localparam int E  = 1 + ADDR_W + W;
  localparam int PW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int FW = $clog2(DELAY + 1);

  // Largest shift a 3-bit register can hold that is still meaningful.
  localparam logic [2:0] SH_MAX = (CH_BITS > 7) ? 3'd7 : 3'(CH_BITS);

  // ---------------------------------------------------------------------
  // Delay buffer: read-before-write at wptr gives exactly DELAY cycles.
  // ---------------------------------------------------------------------
  logic [E-1:0]  mem [DELAY];
  logic [PW-1:0] wptr;
  logic [FW-1:0] fill;
  logic [E-1:0]  rd_entry;
  logic          rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [W-1:0]  rd_word;

  assign rd_entry = mem[wptr];
  // Until every slot has been written once, the RAM holds stale data.
  assign rd_valid = rd_entry[E-1] & (fill == FW'(DELAY));
  assign rd_addr  = rd_entry[W +: ADDR_W];
  assign rd_word  = rd_entry[W-1:0];

  // The RAM array is deliberately not reset; the fill gate hides its contents.
  always_ff @(posedge clk) begin
    mem[wptr] <= {pix_in_valid, write_addr, pix_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      fill <= '0;
    end else begin
      if (wptr == PW'(DELAY - 1)) wptr <= '0;
      else                        wptr <= wptr + PW'(1);
      if (fill != FW'(DELAY))     fill <= fill + FW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Shift configuration, committed on a rising edge of change.
  // ---------------------------------------------------------------------
  logic       change_q;
  logic       commit;
  logic [2:0] sh_new;
  logic [2:0] r_sh, g_sh, b_sh;

  // change_q tracks change even in reset, so a button held across reset
  // release is not seen as an edge.
  always_ff @(posedge clk) begin
    change_q <= change;
  end

  assign commit = change & ~change_q & ~reset;
  assign sh_new = (switch_vals > SH_MAX) ? SH_MAX : switch_vals;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh <= '0;
      g_sh <= '0;
      b_sh <= '0;
    end else if (commit) begin
      if (switch_sels == 2'b00 || switch_sels == 2'b11) r_sh <= sh_new;
      if (switch_sels == 2'b01 || switch_sels == 2'b11) g_sh <= sh_new;
      if (switch_sels == 2'b10 || switch_sels == 2'b11) b_sh <= sh_new;
    end
  end

  // ---------------------------------------------------------------------
  // Quantise stage: one whole-word mask built from the current shifts.
  // ---------------------------------------------------------------------
  function automatic logic [CH_BITS-1:0] ch_mask(input logic [2:0] sh);
    logic [CH_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < CH_BITS; i++) begin
      m[i] = (i >= int'(sh));
    end
    return m;
  endfunction

  logic [CH_BITS-1:0] r_m, g_m, b_m;
  logic [W-1:0]       word_mask;
  logic [W-1:0]       q_word;

  assign r_m = ch_mask(r_sh);
  assign g_m = ch_mask(g_sh);
  assign b_m = ch_mask(b_sh);

  always_comb begin
    word_mask = '0;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      word_mask[k*3*CH_BITS             +: CH_BITS] = b_m;
      word_mask[k*3*CH_BITS + CH_BITS   +: CH_BITS] = g_m;
      word_mask[k*3*CH_BITS + 2*CH_BITS +: CH_BITS] = r_m;
    end
  end

  assign q_word = rd_word & word_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_out       <= '0;
      pix_out_addr  <= '0;
      pix_out_valid <= 1'b0;
    end else begin
      pix_out       <= q_word;
      pix_out_addr  <= rd_addr;
      pix_out_valid <= rd_valid;
    end
  end

endmodule
